// File: rtl/timer_pkg.sv
// Shared kitchen-timer definitions: FSM state encoding, BCD digit limits,
// button indices and a two-digit BCD incrementer.
package timer_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 9;

  localparam int NUM_BTN   = 4;
  localparam int BTN_MIN   = 0;
  localparam int BTN_SEC   = 1;
  localparam int BTN_START = 2;
  localparam int BTN_CLR   = 3;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  // {tens,ones} + 1. The >= compares keep any input inside legal BCD.
  function automatic logic [2*DIGIT_W-1:0] bcd2_inc(input logic [2*DIGIT_W-1:0] v,
                                                    input logic [DIGIT_W-1:0]   tens_max);
    logic [DIGIT_W-1:0] t, o;
    t = v[2*DIGIT_W-1:DIGIT_W];
    o = v[DIGIT_W-1:0];
    if (o >= 4'd9) begin
      o = 4'd0;
      t = (t >= tens_max) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Per-button rising-edge detector with power-up arming.
// With AUTO_REPEAT_EN defined, a held button re-fires after REPEAT_DELAY, then every REPEAT_RATE.
module btn_edge
  import timer_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
`ifdef AUTO_REPEAT_EN
  input  logic rpt_en_i,
`endif
  output logic fire_o
);

  logic prev_q;
  logic armed_q;
  logic rise;

  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_cfg
    $error("btn_edge: REPEAT_DELAY and REPEAT_RATE must be non-zero");
  end

  // armed_q only sets once the button has been seen low, so a level held
  // across reset release cannot fake a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      armed_q <= armed_q | ~btn_i;
    end
  end

  assign rise = btn_i & ~prev_q & armed_q;

`ifdef AUTO_REPEAT_EN
  logic [31:0] cnt_q;
  logic        rep_q;
  logic        held;
  logic [31:0] limit;

  assign held  = btn_i & prev_q & armed_q & rpt_en_i;
  assign limit = rep_q ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1);

  always_ff @(posedge clk) begin
    if (rst || !held) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else if (cnt_q == limit) begin
      cnt_q <= '0;
      rep_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fire_o = rise | (held & (cnt_q == limit));
`else
  assign fire_o = rise;
`endif

endmodule

// File: rtl/time_entry.sv
// Kitchen-timer front end: button edges -> BCD MM:SS preset, load strobe, run, alarm.
// Optional AUTO_REPEAT_EN enables hold-to-repeat on the min/sec buttons.
module time_entry
  import timer_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_min,
  input  logic               btn_sec,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               done,
  output logic [DIGIT_W-1:0] bin0,
  output logic [DIGIT_W-1:0] bin1,
  output logic [DIGIT_W-1:0] bin2,
  output logic [DIGIT_W-1:0] bin3,
  output logic               load,
  output logic               run,
  output logic               alarm
);

  state_e                 state_q;
  logic [2*DIGIT_W-1:0]   min_q, sec_q;
  logic [2*DIGIT_W-1:0]   min_inc, sec_inc;
  logic                   load_q, run_q, alarm_q;
  logic [NUM_BTN-1:0]     btn_lvl, fire;
  logic                   preset_zero;

  assign btn_lvl = {btn_clear, btn_start, btn_sec, btn_min};

`ifdef AUTO_REPEAT_EN
  // Only min/sec repeat, and only while editing; leaving SET resets the counters.
  logic [NUM_BTN-1:0] rpt_en;
  assign rpt_en = {2'b00, {2{state_q == SET}}};
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_lvl[i]),
`ifdef AUTO_REPEAT_EN
      .rpt_en_i (rpt_en[i]),
`endif
      .fire_o   (fire[i])
    );
  end

  assign min_inc     = bcd2_inc(min_q, 4'(MIN_TENS_MAX));
  assign sec_inc     = bcd2_inc(sec_q, 4'(SEC_TENS_MAX));
  assign preset_zero = (min_q == '0) && (sec_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SET;
      min_q   <= '0;
      sec_q   <= '0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        SET: begin
          if (fire[BTN_CLR]) begin
            min_q <= '0;
            sec_q <= '0;
          end else if (fire[BTN_START]) begin
            if (!preset_zero) begin
              state_q <= RUN;
              load_q  <= 1'b1;
              run_q   <= 1'b1;
            end
          end else begin
            if (fire[BTN_MIN]) min_q <= min_inc;
            if (fire[BTN_SEC]) sec_q <= sec_inc;
          end
        end
        RUN: begin
          if (fire[BTN_CLR]) begin
            state_q <= SET;
            run_q   <= 1'b0;
          end else if (fire[BTN_START]) begin
            state_q <= PAUSE;
            run_q   <= 1'b0;
          end else if (done) begin
            state_q <= ALARM;
            run_q   <= 1'b0;
            alarm_q <= 1'b1;
          end
        end
        PAUSE: begin
          if (fire[BTN_CLR]) begin
            state_q <= SET;
          end else if (fire[BTN_START]) begin
            // Resume without load: the countdown keeps its partially spent value.
            state_q <= RUN;
            run_q   <= 1'b1;
          end
        end
        ALARM: begin
          if (|fire) begin
            state_q <= SET;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= SET;
          run_q   <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bin0  = sec_q[DIGIT_W-1:0];
  assign bin1  = sec_q[2*DIGIT_W-1:DIGIT_W];
  assign bin2  = min_q[DIGIT_W-1:0];
  assign bin3  = min_q[2*DIGIT_W-1:DIGIT_W];
  assign load  = load_q;
  assign run   = run_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: integer MM:SS behavioural model checked every cycle,
// plus directed presses with literal expectations.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_min = 1'b0, btn_sec = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
  logic       done = 1'b0;
  logic [3:0] bin0, bin1, bin2, bin3;
  logic       load, run, alarm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_entry dut (
    .clk       (clk),
    .rst       (rst),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .done      (done),
    .bin0      (bin0),
    .bin1      (bin1),
    .bin2      (bin2),
    .bin3      (bin3),
    .load      (load),
    .run       (run),
    .alarm     (alarm)
  );

  // Model: preset kept as plain minutes/seconds integers; mode 0=set 1=run 2=pause 3=alarm.
  int         m_mode = 0, m_mm = 0, m_ss = 0;
  bit         m_load = 0, m_run = 0, m_alarm = 0;
  logic [3:0] m_prev = '0, m_arm = '0, m_ev;

  function automatic logic [18:0] dut_vec();
    return {bin3, bin2, bin1, bin0, load, run, alarm};
  endfunction

  function automatic logic [18:0] model_vec();
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10), m_load, m_run, m_alarm};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got mmss=%h lra=%b expected mmss=%h lra=%b",
               name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] b;
    b = {btn_clear, btn_start, btn_sec, btn_min};
    if (rst) begin
      m_mode = 0; m_mm = 0; m_ss = 0;
      m_load = 0; m_run = 0; m_alarm = 0;
      m_prev = '0; m_arm = '0;
    end else begin
      for (int i = 0; i < 4; i++) m_ev[i] = b[i] && !m_prev[i] && m_arm[i];
      m_arm  = m_arm | ~b;
      m_prev = b;
      m_load = 0;
      case (m_mode)
        0: if (m_ev[3]) begin m_mm = 0; m_ss = 0; end
           else if (m_ev[2]) begin
             if (m_mm != 0 || m_ss != 0) begin m_mode = 1; m_load = 1; m_run = 1; end
           end else begin
             if (m_ev[0]) m_mm = (m_mm + 1) % 100;
             if (m_ev[1]) m_ss = (m_ss + 1) % 60;
           end
        1: if (m_ev[3]) begin m_mode = 0; m_run = 0; end
           else if (m_ev[2]) begin m_mode = 2; m_run = 0; end
           else if (done) begin m_mode = 3; m_run = 0; m_alarm = 1; end
        2: if (m_ev[3]) m_mode = 0;
           else if (m_ev[2]) begin m_mode = 1; m_run = 1; end
        default: if (m_ev != 0) begin m_mode = 0; m_alarm = 0; end
      endcase
    end
    #2;
    check("cycle", dut_vec(), model_vec());
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int i, input logic v);
    case (i)
      0: btn_min = v;
      1: btn_sec = v;
      2: btn_start = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int i);
    set_btn(i, 1'b1); cyc(1);
    set_btn(i, 1'b0); cyc(1);
  endtask

  // Press and check the outputs in the very cycle the action lands.
  task automatic strobe(input int i, input string name, input logic [18:0] exp);
    set_btn(i, 1'b1);
    @(posedge clk); #3;
    check(name, dut_vec(), exp);
    @(negedge clk);
    set_btn(i, 1'b0);
    cyc(1);
  endtask

  initial begin
    cyc(2);
    check("reset", dut_vec(), {16'h0000, 3'b000});
    rst = 1'b0;
    cyc(2);

    repeat (3) press(1);
    repeat (2) press(0);
    check("preset_0203", dut_vec(), {16'h0203, 3'b000});
    press(3);
    check("clear_in_set", dut_vec(), {16'h0000, 3'b000});

    repeat (59) press(1);
    check("sec_59", dut_vec(), {16'h0059, 3'b000});
    press(1);
    check("sec_wrap_no_carry", dut_vec(), {16'h0000, 3'b000});
    repeat (99) press(0);
    check("min_99", dut_vec(), {16'h9900, 3'b000});
    press(1);
    press(0);
    check("min_wrap", dut_vec(), {16'h0001, 3'b000});

    press(3);
    press(0);
    strobe(2, "start_load", {16'h0100, 3'b110});
    check("load_one_cycle", dut_vec(), {16'h0100, 3'b010});
    press(1);
    check("sec_ignored_in_run", dut_vec(), {16'h0100, 3'b010});
    strobe(2, "pause", {16'h0100, 3'b000});
    strobe(2, "resume_no_load", {16'h0100, 3'b010});

    done = 1'b1;
    @(posedge clk); #3;
    check("done_to_alarm", dut_vec(), {16'h0100, 3'b001});
    @(negedge clk);
    done = 1'b0;
    cyc(2);
    check("alarm_hold", dut_vec(), {16'h0100, 3'b001});
    press(1);
    check("alarm_ack", dut_vec(), {16'h0100, 3'b000});

    press(3);
    strobe(2, "start_at_zero", {16'h0000, 3'b000});
    done = 1'b1;
    cyc(3);
    done = 1'b0;
    check("done_in_set", dut_vec(), {16'h0000, 3'b000});

    press(0);
    strobe(2, "start_again", {16'h0100, 3'b110});
    btn_clear = 1'b1;
    btn_start = 1'b1;
    @(posedge clk); #3;
    check("clear_beats_start", dut_vec(), {16'h0100, 3'b000});
    @(negedge clk);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    cyc(1);
    // A load here shows the machine went to SET rather than PAUSE.
    strobe(2, "restart_from_set", {16'h0100, 3'b110});

    rst = 1'b1;
    btn_min = 1'b1;
    @(posedge clk); #3;
    check("rst_mid_run", dut_vec(), {16'h0000, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    check("held_through_rst", dut_vec(), {16'h0000, 3'b000});
    btn_min = 1'b0;
    cyc(1);
    press(0);
    check("repress_after_rst", dut_vec(), {16'h0100, 3'b000});

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
